mem_stream_loader: RTL and testbench

- Runtime alternative to elaboration-time INIT_XX preload of the MicroBlaze LMB instruction BRAM.
- Accepts a framed byte stream (e.g. from a UART receiver), packs bytes into 32-bit little-endian words and writes them to the BRAM's 32-bit native port; the 16 x 2-bit device slicing stays inside the memory generator.
- Holds the CPU in reset until a frame passes its checksum, then releases it.

---
 rtl/mem_loader_pkg.sv | 29 ++
 rtl/mem_stream_loader_packer.sv | 34 +++
 rtl/mem_stream_loader.sv | 168 ++++++++++++++++
 tb/tb_mem_stream_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the runtime LMB BRAM stream loader.
// The state encoding is fixed at 3 bits so it can be probed the same way on every build.
package mem_loader_pkg;

    localparam logic [31:0] MAGIC_DEFAULT  = 32'hB007_10AD;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        HDR_ADDR = 3'd1,
        HDR_CNT  = 3'd2,
        DATA     = 3'd3,
        CKSUM    = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    // Drop byte b into lane 'lane' of a little-endian 32-bit word.
    function automatic logic [31:0] lane_insert(input logic [31:0]       w,
                                                input logic [LANE_W-1:0] lane,
                                                input logic [7:0]        b);
        logic [31:0] r;
        r = w;
        r[8*lane +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_stream_loader_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words.
// word/word_valid are combinational so the consumer sees the word on the 4th byte's cycle.
module byte_word_packer
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [LANE_W-1:0] lane;
    logic [31:0]       acc_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane     <= '0;
            acc_word <= '0;
        end else if (clear) begin
            lane     <= '0;
            acc_word <= '0;
        end else if (in_valid) begin
            lane     <= lane + 1'b1;
            acc_word <= lane_insert(acc_word, lane, in_byte);
        end
    end

    assign word_valid = in_valid && !clear && (lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word       = lane_insert(acc_word, lane, in_byte);

endmodule

// File: rtl/mem_stream_loader.sv
// Runtime loader for the MicroBlaze LMB instruction BRAM: parses a framed byte
// stream, writes the payload words and releases the CPU once the checksum matches.
module mem_stream_loader
    import mem_loader_pkg::*;
#(
    parameter int          MEM_SIZE = 64,
    parameter int          ADDR_W   = $clog2(MEM_SIZE*256),
    parameter logic [31:0] MAGIC    = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [32:0] DEPTH = 33'(MEM_SIZE*256);

    state_t            state;
    logic [1:0]        magic_idx;
    logic [31:0]       a_q;
    logic [31:0]       acc;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   remaining;

    logic              fire;
    logic              sync_phase;
    logic              sync_match;
    logic [7:0]        magic_byte;
    logic              word_valid;
    logic [31:0]       word;
    logic [32:0]       end_addr;
    logic              range_bad;

    assign fire       = s_valid && s_ready;
    // DONE/ERR last one cycle but still hunt for MAGIC so frames can run back-to-back.
    assign sync_phase = (state == SYNC) || (state == DONE) || (state == ERR);
    assign magic_byte = MAGIC[8*magic_idx +: 8];
    assign sync_match = fire && sync_phase && (magic_idx == 2'd3) && (s_data == magic_byte);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (sync_match),
        .in_valid   (fire && !sync_phase),
        .in_byte    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // 33-bit sum so a huge A+N cannot wrap back into range.
    assign end_addr  = {1'b0, a_q} + {1'b0, word};
    assign range_bad = (end_addr > DEPTH) || (({1'b0, a_q} >= DEPTH) && (word != 32'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SYNC;
            magic_idx    <= 2'd0;
            a_q          <= '0;
            acc          <= '0;
            wr_addr      <= '0;
            remaining    <= '0;
            s_ready      <= 1'b0;
            bram_en      <= 1'b0;
            bram_we      <= 4'h0;
            bram_addr    <= '0;
            bram_wdata   <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            s_ready <= 1'b1;
            bram_en <= 1'b0;
            bram_we <= 4'h0;

            if (fire) begin
                case (state)
                    SYNC, DONE, ERR: begin
                        if (s_data == magic_byte) begin
                            if (magic_idx == 2'd3) begin
                                magic_idx    <= 2'd0;
                                state        <= HDR_ADDR;
                                cpu_hold     <= 1'b1;
                                done         <= 1'b0;
                                err          <= 1'b0;
                                words_loaded <= '0;
                                acc          <= '0;
                            end else begin
                                magic_idx <= magic_idx + 1'b1;
                                state     <= SYNC;
                            end
                        end else begin
                            // A stray first-sync byte restarts the hunt at index 1.
                            magic_idx <= (s_data == MAGIC[7:0]) ? 2'd1 : 2'd0;
                            state     <= SYNC;
                        end
                    end

                    HDR_ADDR: begin
                        if (word_valid) begin
                            a_q   <= word;
                            state <= HDR_CNT;
                        end
                    end

                    HDR_CNT: begin
                        if (word_valid) begin
                            wr_addr   <= a_q[ADDR_W-1:0];
                            remaining <= word[ADDR_W:0];
                            if (range_bad) begin
                                state    <= ERR;
                                err      <= 1'b1;
                                cpu_hold <= 1'b1;
                            end else if (word == 32'd0) begin
                                state <= CKSUM;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end

                    DATA: begin
                        if (word_valid) begin
                            bram_en      <= 1'b1;
                            bram_we      <= 4'hF;
                            bram_addr    <= wr_addr;
                            bram_wdata   <= word;
                            wr_addr      <= wr_addr + 1'b1;
                            acc          <= acc + word;
                            words_loaded <= words_loaded + 1'b1;
                            remaining    <= remaining - 1'b1;
                            if (remaining == (ADDR_W+1)'(1))
                                state <= CKSUM;
                        end
                    end

                    CKSUM: begin
                        if (word_valid) begin
                            if (word == acc) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state    <= ERR;
                                err      <= 1'b1;
                                cpu_hold <= 1'b1;
                            end
                        end
                    end

                    default: state <= SYNC;
                endcase
            end else if ((state == DONE) || (state == ERR)) begin
                state <= SYNC;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed bench for mem_stream_loader: a table of frames plus hand-written
// sequences for sync hunting, gaps and mid-frame reset.
module tb_mem_stream_loader;
    import mem_loader_pkg::*;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [7:0]        s_data = 8'h00;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    mem_stream_loader #(.MEM_SIZE(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write strobe seen on a falling edge is logged.
    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    logic [3:0]        wq_we[$];

    always @(negedge clk) begin
        if (rst_n && bram_en) begin
            wq_addr.push_back(bram_addr);
            wq_data.push_back(bram_wdata);
            wq_we.push_back(bram_we);
        end
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_we.delete();
    endtask

    // Called and returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        bit ok;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (s_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_max);
    endtask

    typedef struct {
        logic [31:0]       a;
        logic [31:0]       n;
        logic [31:0]       c;
        logic [2:0][31:0]  d;
        bit                body;
        int                gap;
        bit                e_done;
        bit                e_err;
        int                e_wl;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] n,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] c, input bit body, input int gap,
                                input bit e_done, input bit e_err, input int e_wl);
        vec_t v;
        v.a = a; v.n = n; v.c = c;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        v.body = body; v.gap = gap;
        v.e_done = e_done; v.e_err = e_err; v.e_wl = e_wl;
        return v;
    endfunction

    task automatic send_frame(input vec_t v, input int idx);
        int nw;
        logic [ADDR_W-1:0] ea;
        clear_log();
        send_word(MAGIC_DEFAULT, v.gap);
        send_word(v.a, v.gap);
        send_word(v.n, v.gap);
        nw = 0;
        if (v.body) begin
            nw = int'(v.n);
            for (int k = 0; k < nw; k++) begin
                send_word(v.d[k], v.gap);
                ea = ADDR_W'(v.a + 32'(k));
                check($sformatf("v%0d_wr%0d_lat_en", idx, k), 32'(bram_en), 32'd1);
                check($sformatf("v%0d_wr%0d_lat_addr", idx, k), 32'(bram_addr), 32'(ea));
            end
            send_word(v.c, v.gap);
        end
        check($sformatf("v%0d_done", idx), 32'(done), 32'(v.e_done));
        check($sformatf("v%0d_err", idx), 32'(err), 32'(v.e_err));
        check($sformatf("v%0d_cpu_hold", idx), 32'(cpu_hold), 32'(!v.e_done));
        check($sformatf("v%0d_words_loaded", idx), 32'(words_loaded), 32'(v.e_wl));
        check($sformatf("v%0d_nwrites", idx), 32'(wq_addr.size()), 32'(nw));
        for (int k = 0; k < nw && k < wq_addr.size(); k++) begin
            ea = ADDR_W'(v.a + 32'(k));
            check($sformatf("v%0d_w%0d_addr", idx, k), 32'(wq_addr[k]), 32'(ea));
            check($sformatf("v%0d_w%0d_data", idx, k), wq_data[k], v.d[k]);
            check($sformatf("v%0d_w%0d_we", idx, k), 32'(wq_we[k]), 32'hF);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_bram_en"}, 32'(bram_en), 32'd0);
        check({tag, "_bram_we"}, 32'(bram_we), 32'd0);
        check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
        check({tag, "_bram_wdata"}, bram_wdata, 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        //              A             N      d0            d1            d2            C             body gap done err wl
        vecs[0] = mk(32'h10,       32'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h66666666, 1, 0, 1, 0, 3);
        vecs[1] = mk(32'h10,       32'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h66666667, 1, 0, 0, 1, 3);
        vecs[2] = mk(32'h3FFF,     32'd2, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0);
        vecs[3] = mk(32'h3FFF,     32'd1, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 1);
        vecs[4] = mk(32'h3FFE,     32'd2, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1, 0, 1, 0, 2);
        vecs[5] = mk(32'hFFFFFFFF, 32'd2, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0);
        vecs[6] = mk(32'h20,       32'd0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 1, 0, 0);
        vecs[7] = mk(32'h10,       32'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h66666666, 1, 5, 1, 0, 3);

        #3 rst_n = 1'b0;
        #4 check_reset_state("rst");
        repeat (3) @(posedge clk);
        #1 check_reset_state("rst_held");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_s_ready_rise", 32'(s_ready), 32'd1);

        for (int i = 0; i < 8; i++) send_frame(vecs[i], i);

        // Sync hunt: AD AD 10 07 B0 locks on the second AD; empty frame.
        clear_log();
        send_byte(8'hAD, 0);
        send_word(MAGIC_DEFAULT, 0);
        send_word(32'h30, 0);
        send_word(32'h0, 0);
        send_word(32'h0, 0);
        check("hunt_done", 32'(done), 32'd1);
        check("hunt_err", 32'(err), 32'd0);
        check("hunt_nwrites", 32'(wq_addr.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("hunt_done_hold", 32'(done), 32'd1);
        check("hunt_cpu_hold_hold", 32'(cpu_hold), 32'd0);

        // Reset part-way through the second data word, then a clean frame.
        send_word(MAGIC_DEFAULT, 0);
        send_word(32'h10, 0);
        send_word(32'd3, 0);
        send_word(32'h11111111, 0);
        check("midrst_wl_before", 32'(words_loaded), 32'd1);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        rst_n = 1'b0;
        #1 check_reset_state("midrst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("midrst_s_ready", 32'(s_ready), 32'd1);
        send_frame(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
